// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit
// Multi-cycle RV32M/RV64M arithmetic unit for the EX stage. Multiplies take a
// fixed two cycles; divides and remainders run on an iterative radix-2
// restoring divider, one quotient bit per cycle. Divide-by-zero and signed
// overflow are resolved at accept and finish in one cycle.
//
// Ports
//   clk     in   clock, all state updates on the rising edge
//   reset   in   synchronous active-high reset
//   start   in   request, sampled only while busy=0 (IDLE or DONE)
//   op      in   funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   data1   in   rs1 (multiplicand / dividend)
//   data2   in   rs2 (multiplier / divisor)
//   flush   in   abort the in-flight op; also blocks acceptance in IDLE/DONE
//   busy    out  high while in MUL or DIV
//   done    out  one-cycle pulse, result valid in that cycle
//   result  out  registered result, held until the next done
//
// state  | meaning
// S_IDLE | waiting for start
// S_MUL  | one cycle computing the 2*XLEN product
// S_DIV  | XLEN restoring-division steps, counter counts down to 0
// S_DONE | done pulse; may accept the next op back-to-back

module rv_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [XLEN-1:0]  opa;    // multiplicand, or dividend magnitude shifting into quotient
  logic [XLEN-1:0]  opb;    // multiplier, or divisor magnitude
  logic [XLEN-1:0]  rem;
  logic [CNT_W-1:0] cnt;
  logic             neg_q;
  logic             neg_r;

  // Accept-time decode of the incoming request
  logic            accept;
  logic            signed_in;
  logic            sign1;
  logic            sign2;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_res;

  assign accept    = start && !busy && !flush && (state == S_IDLE || state == S_DONE);
  assign signed_in = ~op[0];  // DIV=100 and REM=110 are the signed divide ops
  assign sign1     = signed_in & data1[XLEN-1];
  assign sign2     = signed_in & data2[XLEN-1];
  assign mag1      = sign1 ? -data1 : data1;
  assign mag2      = sign2 ? -data2 : data2;
  assign div_zero  = (data2 == '0);
  assign div_ovf   = signed_in && (data1 == {1'b1, {(XLEN-1){1'b0}}}) && (data2 == '1);

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = op[1] ? data1 : '1;
    else if (div_ovf)
      special_res = op[1] ? '0 : data1;
  end

  // Multiply: sign-extend each operand to 2*XLEN as the op requires
  logic              ext_a;
  logic              ext_b;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res;

  assign ext_a   = (op_q[1:0] == 2'b01) || (op_q[1:0] == 2'b10);
  assign ext_b   = (op_q[1:0] == 2'b01);
  assign prod    = {{XLEN{ext_a & opa[XLEN-1]}}, opa} * {{XLEN{ext_b & opb[XLEN-1]}}, opb};
  assign mul_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // One restoring step. The compare is XLEN+1 wide; when it passes, the
  // difference is below the divisor, so XLEN bits hold it exactly.
  logic [XLEN:0]   rem_sh;
  logic            q_bit;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] div_res;

  assign rem_sh  = {rem, opa[XLEN-1]};
  assign q_bit   = (rem_sh >= {1'b0, opb});
  assign diff    = rem_sh[XLEN-1:0] - opb;
  assign rem_nx  = q_bit ? diff : rem_sh[XLEN-1:0];
  assign quo_nx  = {opa[XLEN-2:0], q_bit};
  assign div_res = op_q[1] ? (neg_r ? -rem_nx : rem_nx)
                           : (neg_q ? -quo_nx : quo_nx);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      op_q   <= '0;
      opa    <= '0;
      opb    <= '0;
      rem    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (accept) begin
            op_q <= op;
            if (!op[2]) begin
              state <= S_MUL;
              busy  <= 1'b1;
              opa   <= data1;
              opb   <= data2;
            end else if (div_zero || div_ovf) begin
              state  <= S_DONE;
              done   <= 1'b1;
              result <= special_res;
            end else begin
              state <= S_DIV;
              busy  <= 1'b1;
              opa   <= mag1;
              opb   <= mag2;
              rem   <= '0;
              cnt   <= CNT_W'(XLEN);
              neg_q <= sign1 ^ sign2;
              neg_r <= sign1;
            end
          end
        end
        S_MUL: begin
          busy <= 1'b0;
          if (flush) begin
            state <= S_IDLE;
          end else begin
            state  <= S_DONE;
            done   <= 1'b1;
            result <= mul_res;
          end
        end
        S_DIV: begin
          if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            opa <= quo_nx;
            rem <= rem_nx;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state  <= S_DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= div_res;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
module tb_rv_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  logic        start64;
  logic [2:0]  op64;
  logic [63:0] d1_64;
  logic [63:0] d2_64;
  logic        flush64;
  logic        busy64;
  logic        done64;
  logic [63:0] res64;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  rv_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .data1(data1),
    .data2(data2), .flush(flush), .busy(busy), .done(done), .result(result)
  );

  rv_muldiv_unit #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .start(start64), .op(op64), .data1(d1_64),
    .data2(d2_64), .flush(flush64), .busy(busy64), .done(done64), .result(res64)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics from plain integer arithmetic
  function automatic logic [31:0] model32(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    int     ia = int'(a);
    int     ib = int'(b);
    longint p;
    logic   ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'h0 : 32'(ia % ib));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Call at a negedge; drives the request in that cycle (t) and returns at
  // the negedge of the done cycle so a follow-up call issues back-to-back.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    logic [31:0] exp;
    int exp_lat;
    int n;
    int bcnt;
    exp = model32(o, a, b);
    if (!o[2])                                               exp_lat = 2;
    else if (b == 0)                                         exp_lat = 1;
    else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) exp_lat = 1;
    else                                                     exp_lat = 33;
    start = 1'b1; op = o; data1 = a; data2 = b;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); data1 = $urandom; data2 = $urandom;
    n = 1; bcnt = 0;
    while (!done && n < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 128'(n), 128'(exp_lat));
    check({tag, "_res"}, 128'(result), 128'(exp));
    check({tag, "_busycyc"}, 128'(bcnt), 128'(exp_lat - 1));
    last_res = exp;
  endtask

  task automatic do_op64(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int exp_lat, input string tag);
    int n;
    start64 = 1'b1; op64 = o; d1_64 = a; d2_64 = b;
    @(negedge clk);
    start64 = 1'b0; d1_64 = {$urandom, $urandom}; d2_64 = {$urandom, $urandom};
    n = 1;
    while (!done64 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 128'(n), 128'(exp_lat));
    check({tag, "_res"}, 128'(res64), 128'(exp));
  endtask

  initial begin
    int n;
    int dcnt;
    logic [2:0]   ro;
    logic [31:0]  ra;
    logic [31:0]  rb;
    logic [127:0] p128;
    logic [63:0]  a64;
    logic [63:0]  b64;

    reset = 1'b1; start = 1'b0; op = '0; data1 = '0; data2 = '0; flush = 1'b0;
    start64 = 1'b0; op64 = '0; d1_64 = '0; d2_64 = '0; flush64 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_result", 128'(result), 128'(0));
    reset = 1'b0;
    @(negedge clk);

    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh");   @(negedge clk);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu"); @(negedge clk);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");  @(negedge clk);
    do_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul");    @(negedge clk);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_neg");        @(negedge clk);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_neg");        @(negedge clk);
    do_op(3'd5, 32'd100, 32'd7, "divu");                 @(negedge clk);
    do_op(3'd7, 32'd100, 32'd7, "remu");                 @(negedge clk);
    do_op(3'd5, 32'd5, 32'd0, "divu_z");                 @(negedge clk);
    do_op(3'd6, 32'd5, 32'd0, "rem_z");                  @(negedge clk);
    do_op(3'd7, 32'd5, 32'd0, "remu_z");                 @(negedge clk);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf"); @(negedge clk);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf"); @(negedge clk);

    // Back-to-back: second request issued in the first op's done cycle
    do_op(3'd0, 32'd3, 32'd4, "b2b_mul");
    do_op(3'd5, 32'd12, 32'd5, "b2b_divu");
    @(negedge clk);

    // Flush at t+10 of a divide
    start = 1'b1; op = 3'd4; data1 = 32'd1000; data2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 128'(busy), 128'(0));
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    check("flush_nodone", 128'(dcnt), 128'(0));
    check("flush_result", 128'(result), 128'(last_res));

    // Flush in IDLE blocks a same-cycle start (divide-by-zero would finish at t+1)
    start = 1'b1; flush = 1'b1; op = 3'd5; data1 = 32'd9; data2 = 32'd0;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("idleflush_busy", 128'(busy), 128'(0));
    check("idleflush_done", 128'(done), 128'(0));
    check("idleflush_result", 128'(result), 128'(last_res));
    @(negedge clk);

    // Reset at t+5 of a divide
    start = 1'b1; op = 3'd5; data1 = 32'd77; data2 = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_result", 128'(result), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_done", 128'(done), 128'(0));
    last_res = '0;
    @(negedge clk);

    // Randomised ops with a bias toward corner operands
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 50)); rb = 32'($urandom_range(1, 9)); end
        3: rb = 32'($signed(-$urandom_range(1, 9)));
        default: ;
      endcase
      do_op(ro, ra, rb, "rand");
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);

    // 64-bit build
    a64 = 64'h8000_0000_0000_0000;
    b64 = 64'd3;
    do_op64(3'd5, a64, b64, a64 / b64, 65, "divu64");
    @(negedge clk);
    a64 = '1;
    b64 = '1;
    p128 = {64'b0, a64} * {64'b0, b64};
    do_op64(3'd3, a64, b64, p128[127:64], 2, "mulhu64");
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_muldiv_unit.md
# rv_muldiv_unit

Parametrised, multi-cycle RV32M/RV64M arithmetic unit for the EX stage of the pipelined core. It takes the M-extension ops out of the single-cycle ALU path: multiplies complete in a fixed 2 cycles, and divides/remainders run on an iterative radix-2 restoring divider. It implements the full RISC-V corner-case semantics for divide-by-zero and signed overflow. A START/BUSY/DONE handshake lets the hazard unit stall the pipeline, and FLUSH aborts an in-flight op on branch mispredict.

## Interface
- XLEN, 32: operand/result width (32 or 64).
- CNT_W, $clog2(XLEN+1): width of the iteration counter.
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  request; sampled only when BUSY=0.
- OP  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- DATA1  in  XLEN  rs1 operand (multiplicand/dividend).
- DATA2  in  XLEN  rs2 operand (multiplier/divisor).
- FLUSH  in  1  abort current op.
- BUSY  out  1  high while an op is in flight (MUL or DIV state).
- DONE  out  1  one-cycle pulse; RESULT is valid in that cycle.
- RESULT  out  XLEN  registered result; holds its value until the next DONE.

## Operation
- States: IDLE, MUL, DIV, DONE. Reset puts the FSM in IDLE with BUSY=0, DONE=0, RESULT=0, and clears the counter and all internal registers.
- Accept condition: START=1 and BUSY=0, in either IDLE or DONE. Accepting in DONE gives back-to-back issue. OP, DATA1 and DATA2 are latched on accept; later changes to these inputs are ignored.
- MUL ops: accept moves the FSM to MUL.
  - In MUL, compute the 2*XLEN product with the operands sign-extended per OP: MULH signed×signed, MULHSU signed×unsigned, MULHU and MUL unsigned.
  - MUL returns product[XLEN-1:0]; MULH, MULHSU and MULHU return product[2XLEN-1:XLEN].
  - FSM then moves to DONE.
- DIV/REM special cases are resolved at accept and go straight to DONE:
  - DATA2==0: quotient = all ones, remainder = DATA1, for both signed and unsigned ops.
  - Signed overflow (DIV/REM with DATA1 = most negative, DATA2 = all ones): quotient = DATA1, remainder = 0.
- DIV/REM normal path: accept moves the FSM to DIV.
  - Signed ops use operand magnitudes. Record neg_q = sign1 XOR sign2 and neg_r = sign1.
  - Each DIV cycle performs one restoring step: shift {rem,quo} left 1, trial-subtract the divisor, and set the quotient bit if the result is non-negative. The counter starts at XLEN and decrements.
  - When the counter reaches 0 after its final step, the FSM moves to DONE. Apply the sign fix as two's-complement negation where the sign flag is set. DIV/DIVU return the quotient, REM/REMU the remainder.
- DONE: RESULT is loaded on entry and DONE=1 for exactly one cycle. The FSM then goes to IDLE, or to MUL/DIV if START is accepted in that cycle.
- FLUSH in MUL or DIV: the FSM goes to IDLE next cycle, no DONE is produced, and RESULT is unchanged.
  - FLUSH has priority over completion.
  - FLUSH in IDLE or DONE has no effect on state, and blocks acceptance of a START in the same cycle.
- RESET has priority over FLUSH and START. RESET mid-op behaves like a flush, and additionally RESULT is set to 0.
- All arithmetic is modulo 2^XLEN, except the full-width product and the XLEN+1-bit trial subtraction.

## Timing
- Accept in cycle t.
- MUL family: DONE=1 and RESULT valid in cycle t+2; BUSY=1 in t+1.
- DIV family, special case: DONE in t+1; BUSY stays 0.
- DIV family, normal: DONE in t+XLEN+1 (t+33 for XLEN=32); BUSY=1 for cycles t+1..t+XLEN.
- Back-to-back: a START accepted in the DONE cycle starts the next op with the same latencies.
- FLUSH asserted in cycle f: BUSY=0 from f+1; a DONE scheduled for f+1 is suppressed.

## Test plan
- MULH, DATA1=0x80000000, DATA2=0x80000000 -> RESULT=0x40000000, DONE at t+2. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF. MULHU on the same operands -> 0xFFFFFFFE. MUL on the same operands -> 0x00000001.
- DIV -7/2 -> 0xFFFFFFFD and REM -7%2 -> 0xFFFFFFFF, each with DONE at t+33 and BUSY high for 32 cycles. DIVU 100/7 -> 14 and REMU -> 2.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, REMU 5/0 -> 5, each with DONE at t+1. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0 at t+1.
- Back-to-back: MUL 3×4 then DIVU 12/5 issued in the DONE cycle -> 12 at t+2, then 2 exactly 33 cycles later; no idle cycle between ops.
- FLUSH at t+10 of a DIV -> BUSY=0 at t+11, no DONE, RESULT keeps its prior value. RESET at t+5 of a DIV -> RESULT=0, BUSY=0, DONE=0.
- XLEN=64 build: DIVU 2^63/3 -> 0x2AAAAAAAAAAAAAAA with DONE at t+65. MULHU (2^64-1)² -> 0xFFFFFFFFFFFFFFFE.
